fifo_tx_serializer: RTL

FIFO_TX_SERIALIZER -- requirements
Module: fifo_tx_serializer

---
 rtl/fifo_tx_serializer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fifo_tx_serializer.sv
// Serializer that pops words from an upstream FIFO and sends them as UART-style frames.
// Optional even-parity bit is compiled in when FIFO_SER_PARITY_EN is defined.
module fifo_tx_serializer #(
    parameter int WIDTH    = 3,
    parameter int BAUD_DIV = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_empty,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_re,
    output logic             o_tx,
    output logic             o_busy,
    output logic             o_done
);

    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH - 1);

`ifdef FIFO_SER_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_LOAD, S_START, S_DATA, S_STOP
    } state_t;
`endif

    state_t             r_state, w_state_next;
    logic [CNT_W-1:0]   r_baud, w_baud_next;
    logic [BIT_W-1:0]   r_bit, w_bit_next;
    logic [WIDTH-1:0]   r_shift, w_shift_next;
    logic               r_tx, w_tx_next;
    logic               w_done;
    logic               w_baud_last;
`ifdef FIFO_SER_PARITY_EN
    logic               r_par, w_par_next;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
`ifdef FIFO_SER_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
`ifdef FIFO_SER_PARITY_EN
            r_par   <= w_par_next;
`endif
        end
    end

    assign w_baud_last = (r_baud == BAUD_LAST);

    // o_tx is registered, so its next value follows the state being entered,
    // keeping the line level aligned with the current state.
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_tx_next    = r_tx;
        w_done       = 1'b0;
`ifdef FIFO_SER_PARITY_EN
        w_par_next   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                w_tx_next = 1'b1;
                if (i_en && !i_empty) begin
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_shift_next = i_data;
                w_baud_next  = '0;
                w_bit_next   = '0;
                w_tx_next    = 1'b0;
                w_state_next = S_START;
`ifdef FIFO_SER_PARITY_EN
                w_par_next   = ^i_data;
`endif
            end
            S_START: begin
                if (w_baud_last) begin
                    w_baud_next  = '0;
                    w_tx_next    = r_shift[0];
                    w_state_next = S_DATA;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            S_DATA: begin
                if (w_baud_last) begin
                    w_baud_next  = '0;
                    w_shift_next = r_shift >> 1;
                    if (r_bit == BIT_LAST) begin
                        w_bit_next = '0;
`ifdef FIFO_SER_PARITY_EN
                        w_tx_next    = r_par;
                        w_state_next = S_PARITY;
`else
                        w_tx_next    = 1'b1;
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_bit_next = r_bit + 1'b1;
                        w_tx_next  = w_shift_next[0];
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
`ifdef FIFO_SER_PARITY_EN
            S_PARITY: begin
                if (w_baud_last) begin
                    w_baud_next  = '0;
                    w_tx_next    = 1'b1;
                    w_state_next = S_STOP;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_baud_last) begin
                    w_baud_next  = '0;
                    w_tx_next    = 1'b1;
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            default: begin
                w_tx_next    = 1'b1;
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign o_re   = (r_state == S_READ);
    assign o_busy = (r_state != S_IDLE);
    assign o_done = w_done;
    assign o_tx   = r_tx;

endmodule
